// File: rtl/prefetch_unit_pkg.sv
// Shared types for the instruction prefetch front-end.
// Holds the fetch FSM state encoding used by the top level.
// No logic here; imported by the other prefetch files.
package prefetch_unit_pkg;

    // IDLE: no request outstanding. WAIT: request at fetch_pc outstanding.
    // DROP: a request issued before a redirect is still outstanding and its
    // data must be thrown away when it completes.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } pf_state_e;

endpackage

// File: rtl/prefetch_unit_if.sv
// Memory-side and decoder-side bundles of the prefetch unit.
// Pure wiring, zero latency.
// mem side: req held until ack; decoder side: valid/ready plus redirect.
interface prefetch_mem_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

interface prefetch_ins_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              ins_valid;
    logic [DATA_W-1:0] ins_data;
    logic [ADDR_W-1:0] ins_pc;
    logic              ins_ready;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;

    modport master (output ins_valid, ins_data, ins_pc,
                    input  ins_ready, redirect, redirect_addr);
    modport slave  (input  ins_valid, ins_data, ins_pc,
                    output ins_ready, redirect, redirect_addr);
endinterface

// File: rtl/prefetch_unit_fifo.sv
// First-word-fall-through buffer of DEPTH entries with flush.
// Push at edge t is visible at head_dat from t+1; pop acts on the current head.
// No internal backpressure: caller must not push when full; pop on empty is ignored.
module prefetch_fifo #(
    parameter int  WIDTH = 64,
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CNT_W'(DEPTH));
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];
    // Flush dominates both push and pop in the same cycle.
    assign do_push  = push && !flush;
    assign do_pop   = pop && !empty && !flush;

    // Pointer and occupancy update; pointers wrap naturally (DEPTH is a power of two).
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through a valid head, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat;
    end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction fetch front-end: req/ack memory port feeding a DEPTH-entry {pc, instr} buffer.
// Ack at edge t -> entry at ins_* from t+1; one instruction/cycle with ack and ready held high.
// Fetches only with buffer credit; redirect flushes the buffer and drops in-flight data.
module prefetch_unit
    import prefetch_unit_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 4,
    parameter int                INC        = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    prefetch_mem_if.master mem,
    prefetch_ins_if.master ins
);
    localparam int                CNT_W      = $clog2(DEPTH) + 1;
    localparam int                ENT_W      = ADDR_W + DATA_W;
    localparam logic [ADDR_W-1:0] INC_A      = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INC - 1));
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);

    pf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
    logic [ADDR_W-1:0] redirect_pc;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  count_next;
    logic [ENT_W-1:0]  head_dat;

    assign redirect_pc = ins.redirect_addr & ALIGN_MASK;

    // Redirect suppresses both the push of acked data and the decoder pop.
    assign fifo_push  = (state_q == ST_WAIT) && mem.mem_ack && !ins.redirect;
    assign fifo_pop   = !fifo_empty && ins.ins_ready && !ins.redirect;
    assign count_next = fifo_count + CNT_W'(fifo_push) - CNT_W'(fifo_pop);

    prefetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (fifo_push),
        .push_dat ({fetch_pc_q, mem.mem_rdata}),
        .pop      (fifo_pop),
        .flush    (ins.redirect),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Memory request: DROP keeps presenting the pre-redirect address until it is acked.
    assign mem.mem_req  = (state_q != ST_IDLE);
    assign mem.mem_addr = (state_q == ST_DROP) ? drop_addr_q : fetch_pc_q;

    // Head is zeroed while empty so the decoder never sees stale storage.
    assign ins.ins_valid = !fifo_empty;
    assign ins.ins_data  = fifo_empty ? '0 : head_dat[DATA_W-1:0];
    assign ins.ins_pc    = fifo_empty ? '0 : head_dat[ENT_W-1:DATA_W];

    // Fetch FSM: next state, next fetch address and the address held across a drop.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        drop_addr_d = drop_addr_q;
        if (ins.redirect) fetch_pc_d = redirect_pc;
        case (state_q)
            ST_IDLE: begin
                if (ins.redirect || (count_next < DEPTH_C)) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (ins.redirect) begin
                    // Acked data in the redirect cycle is discarded; otherwise
                    // the outstanding request must still complete before refetch.
                    if (!mem.mem_ack) begin
                        state_d     = ST_DROP;
                        drop_addr_d = fetch_pc_q;
                    end
                end else if (mem.mem_ack) begin
                    fetch_pc_d = fetch_pc_q + INC_A;
                    if (count_next >= DEPTH_C) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                // A redirect here only retargets fetch_pc; the old request is
                // still pending, and its ack releases the unit to the new address.
                if (mem.mem_ack) state_d = ST_WAIT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= RESET_ADDR;
            drop_addr_q <= RESET_ADDR;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            drop_addr_q <= drop_addr_d;
        end
    end

    // Credit logic must never let an ack land on a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(fifo_push && fifo_full));

endmodule

// File: tb/tb_prefetch_unit.sv
// Directed bench for prefetch_unit with a queue-based scoreboard.
// Stimulus pushes expected fetch addresses and expected decoder outputs;
// a negedge monitor pops and compares on each accepted request and each pop.
module tb_prefetch_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] exp_req[$];
    logic [63:0] exp_ins[$];

    prefetch_mem_if #(.ADDR_W(32), .DATA_W(32)) mif ();
    prefetch_ins_if #(.ADDR_W(32), .DATA_W(32)) iif ();

    prefetch_unit #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .DEPTH      (4),
        .INC        (4),
        .RESET_ADDR (32'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mem   (mif),
        .ins   (iif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: instruction word is a fixed scramble of its address.
    function automatic logic [31:0] data_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_1234;
    endfunction

    always_comb mif.mem_rdata = data_of(mif.mem_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    task automatic exp_fetch(input logic [31:0] a);
        exp_req.push_back(a);
    endtask

    task automatic exp_out(input logic [31:0] pc);
        exp_ins.push_back({pc, data_of(pc)});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        mif.mem_ack = 1'b0;
        iif.ins_ready = 1'b0;
        iif.redirect = 1'b0;
        iif.redirect_addr = 32'h0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mif.mem_req && mif.mem_ack) begin
                if (exp_req.size() == 0) begin
                    check("unexpected_req", {32'h0, mif.mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("mem_addr_sb", {32'h0, mif.mem_addr}, {32'h0, exp_req.pop_front()});
                end
            end
            if (iif.ins_valid && iif.ins_ready && !iif.redirect) begin
                if (exp_ins.size() == 0) begin
                    check("unexpected_ins", {iif.ins_pc, iif.ins_data}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    check("ins_sb", {iif.ins_pc, iif.ins_data}, exp_ins.pop_front());
                end
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        mif.mem_ack = 1'b0;
        iif.ins_ready = 1'b0;
        iif.redirect = 1'b0;
        iif.redirect_addr = 32'h0;
        #1;
        check("rst_mem_req",   {63'h0, mif.mem_req},   64'h0);
        check("rst_mem_addr",  {32'h0, mif.mem_addr},  64'h0);
        check("rst_ins_valid", {63'h0, iif.ins_valid}, 64'h0);
        check("rst_ins_data",  {32'h0, iif.ins_data},  64'h0);
        check("rst_ins_pc",    {32'h0, iif.ins_pc},    64'h0);

        // 1: streaming with ack and ready always high.
        reset_dut();
        mif.mem_ack = 1'b1;
        iif.ins_ready = 1'b1;
        exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8); exp_fetch(32'hC);
        exp_out(32'h0);   exp_out(32'h4);   exp_out(32'h8);   exp_out(32'hC);
        step();
        check("t1_req",  {63'h0, mif.mem_req},  64'h1);
        check("t1_addr", {32'h0, mif.mem_addr}, 64'h0);
        step();
        check("t1_valid", {63'h0, iif.ins_valid}, 64'h1);
        check("t1_pc0",   {32'h0, iif.ins_pc},    64'h0);
        check("t1_addr4", {32'h0, mif.mem_addr},  64'h4);
        step(); step(); step();
        mif.mem_ack = 1'b0;
        check("t1_valid_hold", {63'h0, iif.ins_valid}, 64'h1);
        check("t1_pcC",        {32'h0, iif.ins_pc},    64'hC);
        check("t1_addr10",     {32'h0, mif.mem_addr},  64'h10);
        step(); step();

        // 2: decoder stalled, buffer fills after four fetches, one pop refetches.
        reset_dut();
        mif.mem_ack = 1'b1;
        exp_fetch(32'h0); exp_fetch(32'h4); exp_fetch(32'h8); exp_fetch(32'hC);
        step(); step(); step(); step(); step();
        check("t2_full_noreq", {63'h0, mif.mem_req},   64'h0);
        check("t2_head_pc0",   {32'h0, iif.ins_pc},    64'h0);
        step(); step();
        check("t2_still_idle", {63'h0, mif.mem_req},   64'h0);
        iif.ins_ready = 1'b1;
        exp_out(32'h0);
        exp_fetch(32'h10);
        step();
        iif.ins_ready = 1'b0;
        check("t2_refetch_req",  {63'h0, mif.mem_req},  64'h1);
        check("t2_refetch_addr", {32'h0, mif.mem_addr}, 64'h10);
        check("t2_head_pc4",     {32'h0, iif.ins_pc},   64'h4);
        step();
        check("t2_refull", {63'h0, mif.mem_req}, 64'h0);

        // 3: redirect from IDLE with a full buffer, unaligned target.
        mif.mem_ack = 1'b0;
        iif.redirect = 1'b1;
        iif.redirect_addr = 32'h103;
        exp_fetch(32'h100); exp_fetch(32'h104);
        exp_out(32'h100);   exp_out(32'h104);
        step();
        iif.redirect = 1'b0;
        check("t3_flush_valid", {63'h0, iif.ins_valid}, 64'h0);
        check("t3_req",         {63'h0, mif.mem_req},   64'h1);
        check("t3_addr",        {32'h0, mif.mem_addr},  64'h100);
        mif.mem_ack = 1'b1;
        iif.ins_ready = 1'b1;
        step(); step();
        mif.mem_ack = 1'b0;
        step(); step();

        // 4: redirect while waiting on 0x108 with a late ack.
        iif.redirect = 1'b1;
        iif.redirect_addr = 32'h200;
        step();
        iif.redirect = 1'b0;
        check("t4_drop_addr0", {32'h0, mif.mem_addr},  64'h108);
        check("t4_drop_valid", {63'h0, iif.ins_valid}, 64'h0);
        step();
        check("t4_drop_addr1", {32'h0, mif.mem_addr},  64'h108);
        step();
        check("t4_drop_addr2", {32'h0, mif.mem_addr},  64'h108);
        exp_fetch(32'h108);
        mif.mem_ack = 1'b1;
        step();
        mif.mem_ack = 1'b0;
        check("t4_new_addr",     {32'h0, mif.mem_addr},  64'h200);
        check("t4_dropped_data", {63'h0, iif.ins_valid}, 64'h0);

        // 5: redirect coinciding with ack and pop.
        exp_fetch(32'h200); exp_fetch(32'h204);
        exp_out(32'h200);
        mif.mem_ack = 1'b1;
        step(); step();
        check("t5_pre_pc", {32'h0, iif.ins_pc}, 64'h204);
        iif.redirect = 1'b1;
        iif.redirect_addr = 32'h40;
        exp_fetch(32'h208);
        step();
        iif.redirect = 1'b0;
        mif.mem_ack = 1'b0;
        check("t5_flush_valid", {63'h0, iif.ins_valid}, 64'h0);
        check("t5_addr",        {32'h0, mif.mem_addr},  64'h40);
        check("t5_req",         {63'h0, mif.mem_req},   64'h1);

        // 6: address wrap, then reset asserted mid-WAIT.
        iif.redirect = 1'b1;
        iif.redirect_addr = 32'hFFFF_FFF8;
        mif.mem_ack = 1'b1;
        exp_fetch(32'h40); exp_fetch(32'hFFFF_FFF8); exp_fetch(32'hFFFF_FFFC); exp_fetch(32'h0);
        exp_out(32'hFFFF_FFF8); exp_out(32'hFFFF_FFFC);
        step();
        iif.redirect = 1'b0;
        check("t6_addr_f8", {32'h0, mif.mem_addr}, 64'hFFFF_FFF8);
        step(); step();
        check("t6_wrap", {32'h0, mif.mem_addr}, 64'h0);
        step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_req",   {63'h0, mif.mem_req},   64'h0);
        check("t6_rst_addr",  {32'h0, mif.mem_addr},  64'h0);
        check("t6_rst_valid", {63'h0, iif.ins_valid}, 64'h0);
        check("t6_rst_data",  {32'h0, iif.ins_data},  64'h0);
        check("t6_rst_pc",    {32'h0, iif.ins_pc},    64'h0);
        mif.mem_ack = 1'b0;
        iif.ins_ready = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        check("t6_restart_req",  {63'h0, mif.mem_req},  64'h1);
        check("t6_restart_addr", {32'h0, mif.mem_addr}, 64'h0);
        exp_fetch(32'h0);
        exp_out(32'h0);
        mif.mem_ack = 1'b1;
        iif.ins_ready = 1'b1;
        step();
        mif.mem_ack = 1'b0;
        step(); step();

        check("req_queue_drained", 64'(exp_req.size()), 64'h0);
        check("ins_queue_drained", 64'(exp_ins.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
